// File: rtl/mlp_stream.sv
// Streaming two-layer MLP: y = act(x*W1 + b1)*W2 + b2 (+x), one token per handshake.
// LANES shared MACs sweep each layer one output group at a time; weights are read live from the ports.
//   state    | meaning
//   S_IDLE   | waiting for a token, in_ready high
//   S_L1_MAC | accumulate x[k]*W1 for the current hidden group
//   S_L1_WB  | round, bias, activate into h; clear accumulators
//   S_L2_MAC | accumulate h[k]*W2 for the current output group
//   S_L2_WB  | round, bias, optional residual into y
//   S_OUT    | y valid, waiting for out_ready
module mlp_stream #(
    parameter int IN_DIM     = 16,
    parameter int HID_DIM    = 64,
    parameter int OUT_DIM    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int ACC_WIDTH  = 40,
    parameter int LANES      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [IN_DIM*DATA_WIDTH-1:0]          x_i,
    input  logic [1:0]                            act_mode_i,
    input  logic                                  residual_en_i,
    input  logic [IN_DIM*HID_DIM*DATA_WIDTH-1:0]  w1_i,
    input  logic [HID_DIM*DATA_WIDTH-1:0]         b1_i,
    input  logic [HID_DIM*OUT_DIM*DATA_WIDTH-1:0] w2_i,
    input  logic [OUT_DIM*DATA_WIDTH-1:0]         b2_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [OUT_DIM*DATA_WIDTH-1:0]         y_o,
    output logic                                  busy_o,
    output logic [15:0]                           token_count_o
);
    localparam int DW   = DATA_WIDTH;
    localparam int EW   = ACC_WIDTH + 1;
    localparam int G1   = HID_DIM / LANES;
    localparam int G2   = OUT_DIM / LANES;
    localparam int MAXK = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
    localparam int MAXG = (G1 > G2) ? G1 : G2;
    localparam int KW   = (MAXK > 1) ? $clog2(MAXK) : 1;
    localparam int GW   = (MAXG > 1) ? $clog2(MAXG) : 1;

    localparam logic signed [EW-1:0] RND   = EW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [EW-1:0] Q_MAX = EW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [2:0] {S_IDLE, S_L1_MAC, S_L1_WB, S_L2_MAC, S_L2_WB, S_OUT} state_t;

    state_t                        state_q;
    logic [KW-1:0]                 k_q;
    logic [GW-1:0]                 g_q;
    logic [IN_DIM*DW-1:0]          x_q;
    logic [1:0]                    act_q;
    logic                          res_q;
    logic signed [ACC_WIDTH-1:0]   acc_q [LANES];
    logic [HID_DIM*DW-1:0]         h_q;
    logic [OUT_DIM*DW-1:0]         y_q;
    logic                          out_valid_q;
    logic [15:0]                   count_q;

    logic signed [DW-1:0]          a_op;
    logic signed [DW-1:0]          w_op    [LANES];
    logic signed [ACC_WIDTH-1:0]   mac_d   [LANES];
    logic signed [DW-1:0]          h_wb_d  [LANES];
    logic signed [DW-1:0]          l2_pre  [LANES];
    logic signed [DW-1:0]          y_wb_d  [LANES];

    function automatic logic signed [DW-1:0] quant(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [EW-1:0] r;
        r = ($signed({a[ACC_WIDTH-1], a}) + RND) >>> FRAC_BITS;
        if (r > Q_MAX)      return Q_MAX[DW-1:0];
        else if (r < Q_MIN) return Q_MIN[DW-1:0];
        else                return r[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] satadd(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1])
            return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] act_fn(input logic signed [DW-1:0] v,
                                                     input logic [1:0] mode);
        case (mode)
            2'd0:    return v[DW-1] ? '0 : v;
            2'd1:    return v[DW-1] ? (v >>> 3) : v;
            default: return v;
        endcase
    endfunction

    // Operand fetch is shared by both layers; the unused layer's selects are don't-care.
    always_comb begin
        if (state_q == S_L1_MAC) a_op = x_q[int'(k_q)*DW +: DW];
        else                     a_op = h_q[int'(k_q)*DW +: DW];
        for (int l = 0; l < LANES; l++) begin
            if (state_q == S_L1_MAC)
                w_op[l] = w1_i[(int'(k_q)*HID_DIM + int'(g_q)*LANES + l)*DW +: DW];
            else
                w_op[l] = w2_i[(int'(k_q)*OUT_DIM + int'(g_q)*LANES + l)*DW +: DW];
            mac_d[l]  = ACC_WIDTH'(a_op) * ACC_WIDTH'(w_op[l]);
            h_wb_d[l] = act_fn(satadd(quant(acc_q[l]), b1_i[(int'(g_q)*LANES + l)*DW +: DW]), act_q);
            l2_pre[l] = satadd(quant(acc_q[l]), b2_i[(int'(g_q)*LANES + l)*DW +: DW]);
            y_wb_d[l] = res_q ? satadd(l2_pre[l], x_q[(int'(g_q)*LANES + l)*DW +: DW]) : l2_pre[l];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            g_q         <= '0;
            x_q         <= '0;
            act_q       <= '0;
            res_q       <= 1'b0;
            h_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        x_q     <= x_i;
                        act_q   <= act_mode_i;
                        res_q   <= residual_en_i;
                        k_q     <= KW'(IN_DIM - 1);
                        g_q     <= '0;
                        state_q <= S_L1_MAC;
                    end
                end
                S_L1_MAC, S_L2_MAC: begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + mac_d[l];
                    if (k_q == '0) state_q <= (state_q == S_L1_MAC) ? S_L1_WB : S_L2_WB;
                    else           k_q     <= k_q - KW'(1);
                end
                S_L1_WB: begin
                    for (int l = 0; l < LANES; l++) begin
                        h_q[(int'(g_q)*LANES + l)*DW +: DW] <= h_wb_d[l];
                        acc_q[l] <= '0;
                    end
                    if (g_q == GW'(G1 - 1)) begin
                        g_q     <= '0;
                        k_q     <= KW'(HID_DIM - 1);
                        state_q <= S_L2_MAC;
                    end else begin
                        g_q     <= g_q + GW'(1);
                        k_q     <= KW'(IN_DIM - 1);
                        state_q <= S_L1_MAC;
                    end
                end
                S_L2_WB: begin
                    for (int l = 0; l < LANES; l++) begin
                        y_q[(int'(g_q)*LANES + l)*DW +: DW] <= y_wb_d[l];
                        acc_q[l] <= '0;
                    end
                    k_q <= KW'(HID_DIM - 1);
                    if (g_q == GW'(G2 - 1)) begin
                        g_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        g_q     <= g_q + GW'(1);
                        state_q <= S_L2_MAC;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o    = (state_q == S_IDLE) && !rst_i;
    assign busy_o        = (state_q != S_IDLE);
    assign out_valid_o   = out_valid_q;
    assign y_o           = y_q;
    assign token_count_o = count_q;

endmodule
